// File: rtl/video_fetch_engine.sv
// Scanline pixel fetch/shift engine: VRAM req/ack fetch into a word FIFO, serialised at 1/2/4/8 bpp.
// Optional fine horizontal scroll enabled by defining VIDEO_FETCH_HSCROLL_EN (adds fine_scroll input).
module video_fetch_engine #(
  parameter int ADDR_W         = 19,
  parameter int DATA_W         = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int WORDS_PER_LINE = 64
) (
  input  logic              CLK_VIDEO,
  input  logic              reset_n,
  input  logic              ce_pix,
  input  logic              line_start,
  input  logic [ADDR_W-1:0] line_base,
  input  logic [1:0]        bpp_mode,
`ifdef VIDEO_FETCH_HSCROLL_EN
  input  logic [3:0]        fine_scroll,
`endif
  input  logic              active,
  output logic              vram_req,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic              vram_ack,
  input  logic [DATA_W-1:0] vram_data,
  output logic [7:0]        pix_index,
  output logic              pix_valid,
  output logic              underrun,
  input  logic              underrun_clr,
  output logic              busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int WC_W  = $clog2(WORDS_PER_LINE + 1);
  localparam int SC_W  = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic [1:0]        bpp_q, bpp_d;

  logic [DATA_W-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
  logic              push, push_ok, pop;

  logic [DATA_W-1:0] shift_q, shift_d;
  logic [SC_W-1:0]   scnt_q, scnt_d;
  logic [7:0]        pix_index_q, pix_index_d;
  logic              pix_valid_q, pix_valid_d;
  logic              underrun_q, underrun_d;
`ifdef VIDEO_FETCH_HSCROLL_EN
  logic [3:0]        skip_q, skip_d;
`endif

  logic [DATA_W-1:0] word;
  logic [3:0]        bpp_bits;
  logic [SC_W-1:0]   ppw;
  logic              discard;
  logic              take;

  // Low byte is displayed first and bits are consumed MSB-first, so swap bytes on load.
  function automatic logic [DATA_W-1:0] byte_swap(input logic [DATA_W-1:0] w);
    for (int i = 0; i < DATA_W / 8; i++)
      byte_swap[DATA_W-1-8*i -: 8] = w[8*i +: 8];
  endfunction

  function automatic logic [7:0] top_pix(input logic [DATA_W-1:0] w, input logic [1:0] m);
    case (m)
      2'd0:    top_pix = {7'd0, w[DATA_W-1]};
      2'd1:    top_pix = {6'd0, w[DATA_W-1 -: 2]};
      2'd2:    top_pix = {4'd0, w[DATA_W-1 -: 4]};
      default: top_pix = w[DATA_W-1 -: 8];
    endcase
  endfunction

  assign vram_req  = (state_q == REQ);
  assign busy      = (state_q != IDLE);
  assign vram_addr = addr_q;
  assign pix_index = pix_index_q;
  assign pix_valid = pix_valid_q;
  assign underrun  = underrun_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    bpp_d   = bpp_q;
    push    = 1'b0;
    case (state_q)
      REQ: begin
        if (vram_ack) begin
          push   = 1'b1;
          addr_d = addr_q + ADDR_W'(1);
          wcnt_d = wcnt_q + WC_W'(1);
          if (wcnt_q == WC_W'(WORDS_PER_LINE - 1))
            state_d = IDLE;
          else if ((fifo_cnt_q == CNT_W'(FIFO_DEPTH - 1)) && !pop)
            state_d = HOLD;
        end
      end
      HOLD: begin
        if ((fifo_cnt_q != CNT_W'(FIFO_DEPTH)) || pop)
          state_d = REQ;
      end
      default: ;
    endcase
    // A new line aborts whatever is in flight; an ack in this cycle is dropped.
    if (line_start) begin
      push    = 1'b0;
      state_d = REQ;
      addr_d  = line_base;
      wcnt_d  = '0;
      bpp_d   = bpp_mode;
    end
  end

  always_comb begin
    push_ok    = push && ((fifo_cnt_q != CNT_W'(FIFO_DEPTH)) || pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: ;
    endcase
    if (line_start) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fifo_cnt_d = '0;
    end
  end

  always_comb begin
    pix_index_d = pix_index_q;
    pix_valid_d = pix_valid_q;
    underrun_d  = underrun_q;
    shift_d     = shift_q;
    scnt_d      = scnt_q;
    pop         = 1'b0;
    word        = byte_swap(fifo_mem_q[rd_ptr_q]);
    bpp_bits    = 4'd1 << bpp_q;
    ppw         = SC_W'(DATA_W >> bpp_q);
    take        = active && ce_pix;
    discard     = 1'b0;
`ifdef VIDEO_FETCH_HSCROLL_EN
    skip_d      = skip_q;
    discard     = (skip_q != 4'd0);
`endif
    if (!active) pix_valid_d = 1'b0;
    if (discard) begin
      // Leading scroll pixels are dropped one per clock, independent of ce_pix.
      if (take) pix_valid_d = 1'b0;
      if (scnt_q != '0) begin
        shift_d = shift_q << bpp_bits;
        scnt_d  = scnt_q - SC_W'(1);
`ifdef VIDEO_FETCH_HSCROLL_EN
        skip_d  = skip_q - 4'd1;
`endif
      end else if (fifo_cnt_q != '0) begin
        pop     = 1'b1;
        shift_d = word << bpp_bits;
        scnt_d  = ppw - SC_W'(1);
`ifdef VIDEO_FETCH_HSCROLL_EN
        skip_d  = skip_q - 4'd1;
`endif
      end
    end else if (take) begin
      if (scnt_q != '0) begin
        pix_index_d = top_pix(shift_q, bpp_q);
        pix_valid_d = 1'b1;
        shift_d     = shift_q << bpp_bits;
        scnt_d      = scnt_q - SC_W'(1);
      end else if (fifo_cnt_q != '0) begin
        pop         = 1'b1;
        pix_index_d = top_pix(word, bpp_q);
        pix_valid_d = 1'b1;
        shift_d     = word << bpp_bits;
        scnt_d      = ppw - SC_W'(1);
      end else begin
        pix_index_d = 8'd0;
        pix_valid_d = 1'b0;
        underrun_d  = 1'b1;
      end
    end
    if (underrun_clr) underrun_d = 1'b0;
    if (line_start) begin
      scnt_d = '0;
`ifdef VIDEO_FETCH_HSCROLL_EN
      skip_d = fine_scroll;
`endif
    end
  end

  always_ff @(posedge CLK_VIDEO or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wcnt_q      <= '0;
      bpp_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
      scnt_q      <= '0;
      pix_index_q <= '0;
      pix_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
`ifdef VIDEO_FETCH_HSCROLL_EN
      skip_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wcnt_q      <= wcnt_d;
      bpp_q       <= bpp_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      scnt_q      <= scnt_d;
      pix_index_q <= pix_index_d;
      pix_valid_q <= pix_valid_d;
      underrun_q  <= underrun_d;
`ifdef VIDEO_FETCH_HSCROLL_EN
      skip_q      <= skip_d;
`endif
    end
  end

  // Data-only storage: validity is tracked by the counters above.
  always_ff @(posedge CLK_VIDEO) begin
    shift_q <= shift_d;
    if (push_ok) fifo_mem_q[wr_ptr_q] <= vram_data;
  end

endmodule

// File: tb/tb_video_fetch_engine.sv
// Self-checking bench for video_fetch_engine: table-driven pixel vectors plus fetch/abort/reset sequences.
module tb_video_fetch_engine;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 16;

  logic              clk;
  logic              reset_n;
  logic              ce_pix;
  logic              line_start;
  logic [ADDR_W-1:0] line_base;
  logic [1:0]        bpp_mode;
  logic              active;
  logic              vram_req;
  logic [ADDR_W-1:0] vram_addr;
  logic              vram_ack;
  logic [DATA_W-1:0] vram_data;
  logic [7:0]        pix_index;
  logic              pix_valid;
  logic              underrun;
  logic              underrun_clr;
  logic              busy;

  video_fetch_engine #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(4), .WORDS_PER_LINE(64)
  ) dut (
    .CLK_VIDEO(clk), .reset_n(reset_n), .ce_pix(ce_pix), .line_start(line_start),
    .line_base(line_base), .bpp_mode(bpp_mode),
`ifdef VIDEO_FETCH_HSCROLL_EN
    .fine_scroll(4'd0),
`endif
    .active(active), .vram_req(vram_req), .vram_addr(vram_addr), .vram_ack(vram_ack),
    .vram_data(vram_data), .pix_index(pix_index), .pix_valid(pix_valid),
    .underrun(underrun), .underrun_clr(underrun_clr), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]      bpp;
    logic [15:0]     word;
    int              gap;
    logic [3:0][7:0] px;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  logic [31:0] ack_log[$];
  logic [7:0]  exp_q[$];
  logic        resp_en = 1'b0;
  logic        resp_const = 1'b0;
  logic [15:0] resp_word = 16'h0;
  int          resp_dly = 0;
  int          dly_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock; afterwards the VRAM responder decides this cycle's ack.
  task automatic tick();
    @(posedge clk);
    #1;
    vram_ack = 1'b0;
    if (resp_en && vram_req) begin
      if (dly_cnt >= resp_dly) begin
        vram_ack  = 1'b1;
        vram_data = resp_const ? resp_word : ~vram_addr[15:0];
        ack_log.push_back(32'(vram_addr));
        dly_cnt   = 0;
      end else begin
        dly_cnt++;
      end
    end else begin
      dly_cnt = 0;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[6];
    int   n;
    logic [7:0] e;

    vecs[0] = '{2'd2, 16'hA5C3, 4, {8'h0C, 8'h03, 8'h0A, 8'h05}};
    vecs[1] = '{2'd3, 16'hA5C3, 1, {8'hC3, 8'hA5, 8'hC3, 8'hA5}};
    vecs[2] = '{2'd0, 16'hA5C3, 1, {8'h01, 8'h01, 8'h00, 8'h00}};
    vecs[3] = '{2'd1, 16'h1B4E, 2, {8'h01, 8'h00, 8'h03, 8'h02}};
    vecs[4] = '{2'd2, 16'h1234, 1, {8'h03, 8'h04, 8'h01, 8'h02}};
    vecs[5] = '{2'd0, 16'h0F80, 3, {8'h01, 8'h00, 8'h00, 8'h00}};

    reset_n = 1'b0; ce_pix = 1'b0; line_start = 1'b0; line_base = '0; bpp_mode = 2'd0;
    active = 1'b0; vram_ack = 1'b0; vram_data = '0; underrun_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 32'(vram_req), 0);
    check("rst_addr", 32'(vram_addr), 0);
    check("rst_pix_index", 32'(pix_index), 0);
    check("rst_pix_valid", 32'(pix_valid), 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_busy", 32'(busy), 0);
    reset_n = 1'b1;
    tick();
    check("idle_req", 32'(vram_req), 0);

    // Full line fetch, one-cycle ack delay, pixels drained at 1bpp.
    ack_log.delete();
    resp_en = 1'b1; resp_const = 1'b0; resp_dly = 1;
    line_start = 1'b1; line_base = 19'h01000; bpp_mode = 2'd0;
    tick();
    line_start = 1'b0; active = 1'b1; ce_pix = 1'b1;
    n = 0;
    while (ack_log.size() < 64 && n < 3000) begin
      tick();
      n++;
    end
    check("t1_ack_count", ack_log.size(), 64);
    tick();
    check("t1_busy_end", 32'(busy), 0);
    check("t1_req_end", 32'(vram_req), 0);
    for (int i = 0; i < 64 && i < ack_log.size(); i++)
      check("t1_addr", ack_log[i], 32'h1000 + i);
    repeat (20) tick();
    check("t1_no_more_acks", ack_log.size(), 64);
    check("t1_idle_req", 32'(vram_req), 0);
    active = 1'b0; ce_pix = 1'b0; underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    check("t1_underrun_clr", 32'(underrun), 0);

    // Table-driven pixel vectors with a constant word per line.
    for (int v = 0; v < 6; v++) begin
      resp_en = 1'b1; resp_const = 1'b1; resp_word = vecs[v].word; resp_dly = 0;
      active = 1'b0; ce_pix = 1'b0;
      line_start = 1'b1; line_base = 19'h07000; bpp_mode = vecs[v].bpp;
      for (int k = 0; k < 4; k++) exp_q.push_back(vecs[v].px[3-k]);
      tick();
      line_start = 1'b0;
      repeat (8) tick();
      check("vec_hold_req", 32'(vram_req), 0);
      for (int k = 0; k < 4; k++) begin
        active = 1'b1; ce_pix = 1'b1;
        tick();
        ce_pix = 1'b0;
        e = exp_q.pop_front();
        check("vec_valid", 32'(pix_valid), 1);
        check("vec_index", 32'(pix_index), 32'(e));
        for (int g = 1; g < vecs[v].gap; g++) begin
          tick();
          check("vec_gap_valid", 32'(pix_valid), 1);
          check("vec_gap_index", 32'(pix_index), 32'(e));
        end
      end
      active = 1'b0;
      tick();
      check("vec_inactive_valid", 32'(pix_valid), 0);
      check("vec_inactive_hold", 32'(pix_index), 32'(e));
    end
    check("vec_sb_empty", exp_q.size(), 0);

    // FIFO fills to depth with display inactive; one pop reopens the request.
    ack_log.delete();
    resp_en = 1'b1; resp_const = 1'b0; resp_dly = 0;
    line_start = 1'b1; line_base = 19'h02000; bpp_mode = 2'd3;
    tick();
    line_start = 1'b0;
    repeat (10) tick();
    check("t3_fill_count", ack_log.size(), 4);
    check("t3_hold_req", 32'(vram_req), 0);
    check("t3_hold_busy", 32'(busy), 1);
    active = 1'b1; ce_pix = 1'b1;
    tick();
    active = 1'b0; ce_pix = 1'b0;
    check("t3_req_again", 32'(vram_req), 1);
    check("t3_pix_valid", 32'(pix_valid), 1);
    check("t3_pix_index", 32'(pix_index), 32'h0FF);
    repeat (5) tick();
    check("t3_refill_count", ack_log.size(), 5);
    check("t3_rehold_req", 32'(vram_req), 0);

    // Underrun before any data, sticky, and clear beating a simultaneous set.
    resp_en = 1'b0;
    check("t4_underrun_pre", 32'(underrun), 0);
    line_start = 1'b1; line_base = 19'h03000; bpp_mode = 2'd0;
    tick();
    line_start = 1'b0; active = 1'b1; ce_pix = 1'b1;
    tick();
    check("t4_valid", 32'(pix_valid), 0);
    check("t4_index", 32'(pix_index), 0);
    check("t4_underrun", 32'(underrun), 1);
    active = 1'b0; ce_pix = 1'b0;
    repeat (3) tick();
    check("t4_sticky", 32'(underrun), 1);
    active = 1'b1; ce_pix = 1'b1; underrun_clr = 1'b1;
    tick();
    active = 1'b0; ce_pix = 1'b0; underrun_clr = 1'b0;
    check("t4_clr_priority", 32'(underrun), 0);
    tick();
    check("t4_clr_stays", 32'(underrun), 0);

    // Abort mid-line while the 10th ack is on the bus.
    ack_log.delete();
    resp_en = 1'b1; resp_const = 1'b0; resp_dly = 1;
    line_start = 1'b1; line_base = 19'h04000; bpp_mode = 2'd3;
    active = 1'b1; ce_pix = 1'b1;
    tick();
    line_start = 1'b0;
    n = 0;
    while (ack_log.size() < 10 && n < 200) begin
      tick();
      n++;
    end
    check("t5_ack_count", ack_log.size(), 10);
    line_start = 1'b1; line_base = 19'h05000; resp_en = 1'b0;
    active = 1'b0; ce_pix = 1'b0; underrun_clr = 1'b1;
    tick();
    line_start = 1'b0; underrun_clr = 1'b0;
    check("t5_new_addr", 32'(vram_addr), 32'h05000);
    check("t5_req", 32'(vram_req), 1);
    for (int i = 0; i < 10 && i < ack_log.size(); i++)
      check("t5_addr", ack_log[i], 32'h4000 + i);
    active = 1'b1; ce_pix = 1'b1;
    tick();
    active = 1'b0; ce_pix = 1'b0;
    check("t5_fifo_empty_valid", 32'(pix_valid), 0);
    check("t5_fifo_empty_underrun", 32'(underrun), 1);

    // Asynchronous reset while a request is pending and the FIFO holds data.
    line_start = 1'b1; line_base = 19'h06000; bpp_mode = 2'd0;
    active = 1'b1; ce_pix = 1'b1;
    tick();
    line_start = 1'b0;
    tick();
    active = 1'b0; ce_pix = 1'b0;
    resp_en = 1'b1; resp_const = 1'b0; resp_dly = 0;
    tick();
    tick();
    resp_en = 1'b0;
    tick();
    check("t6_pre_req", 32'(vram_req), 1);
    check("t6_pre_underrun", 32'(underrun), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_async_req", 32'(vram_req), 0);
    check("t6_async_busy", 32'(busy), 0);
    check("t6_async_underrun", 32'(underrun), 0);
    check("t6_async_addr", 32'(vram_addr), 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    active = 1'b1; ce_pix = 1'b1;
    tick();
    active = 1'b0; ce_pix = 1'b0;
    check("t6_fifo_empty_valid", 32'(pix_valid), 0);
    check("t6_fifo_empty_underrun", 32'(underrun), 1);
    check("t6_busy_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_fetch_engine.md
Name: video_fetch_engine

Overview:
- Parametrised pixel fetch and shift engine; successor to the fixed-timing SAM fetch/shift path in the video controller.
- Fetches one scanline of VRAM words through a req/ack handshake into a small FIFO.
- Serialises the words at the pixel enable in 1/2/4/8 bpp.
- Emits palette indices to the CLUT/mixer stage; detects and flags FIFO underrun.

Parameters:
ADDR_W, 19, VRAM word address width
DATA_W, 16, VRAM word width in bits; must be a multiple of 8
FIFO_DEPTH, 4, word FIFO entries; power of two, at least 2
WORDS_PER_LINE, 64, words fetched per line_start

Ports:
CLK_VIDEO  in  1  master video clock
reset_n  in  1  asynchronous active-low reset
ce_pix  in  1  pixel clock enable
line_start  in  1  one-cycle pulse: begin fetching a new line
line_base  in  ADDR_W  first word address, sampled on line_start
bpp_mode  in  2  0=1bpp, 1=2bpp, 2=4bpp, 3=8bpp; sampled on line_start
active  in  1  display window; pixels consumed when active & ce_pix
vram_req  out  1  read request
vram_addr  out  ADDR_W  request address
vram_ack  in  1  one-cycle; vram_data valid this cycle
vram_data  in  DATA_W  read data
pix_index  out  8  palette index, zero-extended
pix_valid  out  1  pix_index holds fetched data
underrun  out  1  sticky: pixel demanded with shifter and FIFO empty
underrun_clr  in  1  clears underrun
busy  out  1  FSM not IDLE

Behaviour:
- Reset values: vram_req=0, vram_addr=0, pix_index=0, pix_valid=0, underrun=0, busy=0. FIFO and shifter are emptied; FSM is IDLE.
- FSM states: IDLE, REQ, HOLD.
  - IDLE: on line_start, latch line_base/bpp_mode, word count=0, flush FIFO and shifter, go to REQ.
  - REQ: vram_req=1; vram_addr stable until vram_ack. On ack: push vram_data, addr+1, count+1.
    - If count reaches WORDS_PER_LINE, go to IDLE.
    - Else if FIFO would be full after the push (pop in the same cycle counts), go to HOLD.
    - Else stay in REQ; vram_req stays high; the next request is presented in the following cycle.
  - HOLD: vram_req=0; go to REQ when the FIFO has at least one free entry.
- At most one request outstanding. vram_ack while vram_req=0 is ignored.
- line_start in REQ or HOLD aborts the line: FIFO and shifter flushed, restart from the new line_base. An ack in that same cycle is discarded.
- vram_addr increments modulo 2^ADDR_W.
- Shifter, acting only when active & ce_pix:
  - Bits per pixel b = 1<<bpp_mode; pixels per word P = DATA_W/b.
  - If the shifter is empty and the FIFO is non-empty: pop a word into the shifter and emit its first pixel in the same cycle.
  - Byte order: the low byte of a word is displayed first. Within a byte the MSB is first, i.e. shifter = byte-swapped vram_data, consumed from the top.
  - pix_index = top b bits, zero-extended to 8. Shift left by b; the word is exhausted after P pixels.
  - If the shifter and FIFO are both empty: pix_index=0, pix_valid=0, underrun<=1.
- Outputs are registered, updated on the clock edge where active & ce_pix is sampled; latency is one clock.
- When active=0, pix_valid=0 and pix_index holds its value.
- underrun_clr takes priority over a simultaneous set.
- FIFO: push and pop in the same cycle when full is legal, and the count is unchanged.
- busy=1 in REQ/HOLD. busy does not reflect residual FIFO/shifter content.

Optional Feature:
- Macro VIDEO_FETCH_HSCROLL_EN adds input fine_scroll [3:0], sampled on line_start.
- With the macro: the first fine_scroll pixels of each line are shifted out internally without being emitted. Discarding consumes no ce_pix slots: the shifter discards one pixel per clock after the first word loads, before the first active & ce_pix emission. Before discarding completes, active & ce_pix gives pix_valid=0 with no underrun. fine_scroll is limited to fewer than P×FIFO_DEPTH.
- Without the macro: the port is absent and behaviour is as above.

Test Plan:
1. Reset released; line_start with line_base=0x1000, bpp_mode=0; ack every request with 1 cycle delay -> 64 requests at 0x1000..0x103F, busy falls after the 64th ack, vram_req never high in IDLE.
2. bpp_mode=2, word 0xA5C3, active and ce_pix every 4 clocks -> pix_index sequence 0x0C,0x03,0x0A,0x05, all pix_valid=1.
3. active=0 while fetching, acks immediate -> exactly FIFO_DEPTH words accepted, state HOLD, vram_req=0. Then one pop -> vram_req reasserts next cycle.
4. active=1 with ce_pix before the first ack -> pix_valid=0, pix_index=0, underrun=1 and sticky. Pulse underrun_clr together with another underrun -> underrun=0.
5. line_start mid-line (count=10, ack same cycle) -> acked word dropped, next vram_addr = new line_base, FIFO empty.
6. reset_n low while vram_req=1 -> vram_req=0 immediately (asynchronous), FIFO empty, underrun=0.
